// File: rtl/bif_bus_arb_if.sv
// Request, grant and transfer-strobe signals shared between the BIF bus arbiter
// and the requesters/slaves it sequences.
interface bif_bus_arb_if;
  logic CLEAR_n;
  logic REFRQ_n;
  logic IBREQ_n;
  logic CRQ_n;
  logic IORQ_n;
  logic IBDRY_n;
  logic IBPERR_n;
  logic RGNT_n;
  logic BGNT_n;
  logic CGNT_n;
  logic IOGNT_n;
  logic BAPR_n;
  logic BUSY;
  logic TOUT;
  logic BERROR_n;

  modport master (
    input  CLEAR_n, REFRQ_n, IBREQ_n, CRQ_n, IORQ_n, IBDRY_n, IBPERR_n,
    output RGNT_n, BGNT_n, CGNT_n, IOGNT_n, BAPR_n, BUSY, TOUT, BERROR_n
  );

  modport slave (
    output CLEAR_n, REFRQ_n, IBREQ_n, CRQ_n, IORQ_n, IBDRY_n, IBPERR_n,
    input  RGNT_n, BGNT_n, CGNT_n, IOGNT_n, BAPR_n, BUSY, TOUT, BERROR_n
  );
endinterface

// File: rtl/bif_bus_arb.sv
// Bus grant arbiter and transfer sequencer for the BIF datapath/BCTL pair.
// Define BIF_ARB_TIMEOUT_EN to build the WAIT_DRY timeout supervisor.
module bif_bus_arb #(
  parameter int APR_CYCLES  = 2,
  parameter int TURN_CYCLES = 1,
  parameter int TOUT_CYCLES = 255,
  parameter int TOUT_W      = 8
) (
  input  logic         sysclk,
  input  logic         sys_rst,
  bif_bus_arb_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_APR,
    S_WAIT_DRY,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_REF,
    OWN_EXT,
    OWN_CPU,
    OWN_IO
  } owner_t;

  localparam int PHASE_MAX = (APR_CYCLES > TURN_CYCLES) ? APR_CYCLES : TURN_CYCLES;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam logic [PW-1:0] APR_LAST  = PW'(APR_CYCLES - 1);
  localparam logic [PW-1:0] TURN_LAST = PW'(TURN_CYCLES - 1);

  if (APR_CYCLES < 1 || TURN_CYCLES < 1 || TOUT_W < 1 ||
      TOUT_CYCLES < 1 || TOUT_CYCLES > ((1 << TOUT_W) - 1)) begin : g_bad_params
    $error("bif_bus_arb: illegal parameter combination");
  end

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  owner_t        winner;
  owner_t        cpu_owner;
  logic          ptr_cpu_q, ptr_cpu_d;
  logic [PW-1:0] phase_cnt_q, phase_cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic          bapr_q, bapr_d;

  logic req_ref, req_ext, req_mem, req_io, any_cpu, any_req;
  logic clear, dry, perr;
  logic tout_hit, tout_pulse, perr_pulse;

  assign req_ref = ~bus.REFRQ_n;
  assign req_ext = ~bus.IBREQ_n;
  assign req_mem = ~bus.CRQ_n;
  assign req_io  = ~bus.IORQ_n;
  assign clear   = ~bus.CLEAR_n;
  assign dry     = ~bus.IBDRY_n;
  assign perr    = ~bus.IBPERR_n;
  assign any_cpu = req_mem | req_io;
  assign any_req = req_ref | req_ext | any_cpu;

  // Refresh always wins; ptr_cpu_q says which class gets the tie when both
  // the external master and the CPU are asking.
  always_comb begin
    cpu_owner = req_mem ? OWN_CPU : OWN_IO;
    winner    = cpu_owner;
    if (req_ref) begin
      winner = OWN_REF;
    end else if (req_ext && any_cpu) begin
      winner = ptr_cpu_q ? cpu_owner : OWN_EXT;
    end else if (req_ext) begin
      winner = OWN_EXT;
    end
  end

`ifdef BIF_ARB_TIMEOUT_EN
  localparam logic [TOUT_W-1:0] TOUT_LIM = TOUT_W'(TOUT_CYCLES);

  logic [TOUT_W-1:0] tout_cnt_q, tout_cnt_d, tout_next;

  // The timeout fires in the cycle whose closing edge brings the count to the limit.
  always_comb begin
    tout_next  = (tout_cnt_q == '1) ? tout_cnt_q : tout_cnt_q + 1'b1;
    tout_hit   = (state_q == S_WAIT_DRY) && !dry && (tout_next >= TOUT_LIM);
    tout_cnt_d = ((state_q == S_WAIT_DRY) && (state_d == S_WAIT_DRY)) ? tout_next : '0;
  end

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      tout_cnt_q <= '0;
    end else begin
      tout_cnt_q <= tout_cnt_d;
    end
  end
`else
  assign tout_hit = 1'b0;
`endif

  assign tout_pulse = tout_hit && !clear;
  assign perr_pulse = (state_q == S_WAIT_DRY) && dry && perr && !clear;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_cpu_d   = ptr_cpu_q;
    phase_cnt_d = phase_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d = winner;
          state_d = S_GRANT;
          if (winner != OWN_REF) begin
            ptr_cpu_d = ~ptr_cpu_q;
          end
        end
      end
      S_GRANT: begin
        state_d     = S_APR;
        phase_cnt_d = '0;
      end
      S_APR: begin
        if (phase_cnt_q == APR_LAST) begin
          state_d     = S_WAIT_DRY;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = (phase_cnt_q == '1) ? phase_cnt_q : phase_cnt_q + 1'b1;
        end
      end
      S_WAIT_DRY: begin
        if (dry || tout_hit) begin
          state_d     = S_DONE;
          phase_cnt_d = '0;
        end
      end
      S_DONE: begin
        if (phase_cnt_q == TURN_LAST) begin
          state_d     = S_IDLE;
          phase_cnt_d = '0;
        end else begin
          phase_cnt_d = (phase_cnt_q == '1) ? phase_cnt_q : phase_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        phase_cnt_d = '0;
      end
    endcase

    // A synchronous abort discards the transfer but keeps the round-robin history.
    if (clear) begin
      state_d     = S_IDLE;
      owner_d     = owner_q;
      ptr_cpu_d   = ptr_cpu_q;
      phase_cnt_d = '0;
    end
  end

  always_comb begin
    gnt_d  = 4'b0000;
    bapr_d = (state_d == S_APR);
    if ((state_d == S_GRANT) || (state_d == S_APR) || (state_d == S_WAIT_DRY)) begin
      unique case (owner_d)
        OWN_REF: gnt_d = 4'b0001;
        OWN_EXT: gnt_d = 4'b0010;
        OWN_CPU: gnt_d = 4'b0100;
        OWN_IO:  gnt_d = 4'b1000;
        default: gnt_d = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_CPU;
      ptr_cpu_q   <= 1'b1;
      phase_cnt_q <= '0;
      gnt_q       <= 4'b0000;
      bapr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_cpu_q   <= ptr_cpu_d;
      phase_cnt_q <= phase_cnt_d;
      gnt_q       <= gnt_d;
      bapr_q      <= bapr_d;
    end
  end

  assign bus.RGNT_n   = ~gnt_q[0];
  assign bus.BGNT_n   = ~gnt_q[1];
  assign bus.CGNT_n   = ~gnt_q[2];
  assign bus.IOGNT_n  = ~gnt_q[3];
  assign bus.BAPR_n   = ~bapr_q;
  assign bus.BUSY     = (state_q != S_IDLE);
  assign bus.TOUT     = tout_pulse;
  assign bus.BERROR_n = ~(tout_pulse | perr_pulse);

endmodule

// File: tb/tb_bif_bus_arb.sv
// Directed self-checking bench for bif_bus_arb (APR=2, TURN=1, TOUT=4).
// Define BIF_ARB_TIMEOUT_EN for both bench and RTL to exercise the timeout build.
module tb_bif_bus_arb;

  logic sysclk;
  logic sys_rst;
  int   errors;
  int   checks;

  bif_bus_arb_if bus ();

  bif_bus_arb #(
    .APR_CYCLES (2),
    .TURN_CYCLES(1),
    .TOUT_CYCLES(4),
    .TOUT_W     (8)
  ) u_dut (
    .sysclk (sysclk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // {RGNT_n, BGNT_n, CGNT_n, IOGNT_n, BAPR_n, BUSY, TOUT, BERROR_n}
  logic [7:0] obs;
  assign obs = {bus.RGNT_n, bus.BGNT_n, bus.CGNT_n, bus.IOGNT_n,
                bus.BAPR_n, bus.BUSY, bus.TOUT, bus.BERROR_n};

  localparam logic [7:0] IDLE_V = 8'b1111_1001;
  localparam logic [3:0] G_R  = 4'b0111;
  localparam logic [3:0] G_B  = 4'b1011;
  localparam logic [3:0] G_C  = 4'b1101;
  localparam logic [3:0] G_IO = 4'b1110;
  localparam logic [3:0] G_NO = 4'b1111;

  function automatic logic [7:0] vec(input logic [3:0] g, input logic bapr,
                                     input logic busy, input logic tout, input logic berr);
    return {g, bapr, busy, tout, berr};
  endfunction

  task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] exp);
    int n;
    n = 0;
    while (obs[7:4] === G_NO && n < 40) begin
      @(negedge sysclk);
      n++;
    end
    check_output(tag, {4'h0, obs[7:4]}, {4'h0, exp});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (obs[2] !== 1'b0 && n < 40) begin
      @(negedge sysclk);
      n++;
    end
    check_output(tag, obs, IDLE_V);
  endtask

  logic [7:0] t2 [1:8];
  int         bad;

  initial begin
    errors = 0;
    checks = 0;
    sys_rst      = 1'b1;
    bus.CLEAR_n  = 1'b1;
    bus.REFRQ_n  = 1'b1;
    bus.IBREQ_n  = 1'b1;
    bus.CRQ_n    = 1'b1;
    bus.IORQ_n   = 1'b1;
    bus.IBDRY_n  = 1'b1;
    bus.IBPERR_n = 1'b1;

    #1 check_output("reset_state", obs, IDLE_V);
    repeat (2) @(negedge sysclk);
    sys_rst = 1'b0;

    $display("[TB] test 1: idle after reset");
    for (int c = 0; c < 10; c++) begin
      @(negedge sysclk);
      check_output($sformatf("t1_idle_c%0d", c), obs, IDLE_V);
    end

    $display("[TB] test 2: single CPU memory transfer timing");
    t2[1] = vec(G_C,  1'b1, 1'b1, 1'b0, 1'b1);
    t2[2] = vec(G_C,  1'b0, 1'b1, 1'b0, 1'b1);
    t2[3] = vec(G_C,  1'b0, 1'b1, 1'b0, 1'b1);
    t2[4] = vec(G_C,  1'b1, 1'b1, 1'b0, 1'b1);
    t2[5] = vec(G_C,  1'b1, 1'b1, 1'b0, 1'b1);
    t2[6] = vec(G_C,  1'b1, 1'b1, 1'b0, 1'b1);
    t2[7] = vec(G_NO, 1'b1, 1'b1, 1'b0, 1'b1);
    t2[8] = IDLE_V;
    bus.CRQ_n = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge sysclk);
      check_output($sformatf("t2_c%0d", c), obs, t2[c]);
      if (c == 1) bus.CRQ_n = 1'b1;
      if (c == 6) bus.IBDRY_n = 1'b0;
      if (c == 7) bus.IBDRY_n = 1'b1;
    end

    $display("[TB] test 3: refresh priority then round robin");
    bus.IBDRY_n = 1'b0;
    bus.REFRQ_n = 1'b0;
    bus.IBREQ_n = 1'b0;
    bus.CRQ_n   = 1'b0;
    expect_grant("t3_r1", G_R);
    wait_idle("t3_r1_done");
    expect_grant("t3_r2", G_R);
    wait_idle("t3_r2_done");
    expect_grant("t3_r3", G_R);
    bus.REFRQ_n = 1'b1;
    wait_idle("t3_r3_done");
    expect_grant("t3_b1", G_B);
    wait_idle("t3_b1_done");
    expect_grant("t3_c1", G_C);
    wait_idle("t3_c1_done");
    expect_grant("t3_b2", G_B);
    wait_idle("t3_b2_done");
    expect_grant("t3_c2", G_C);
    bus.IBREQ_n = 1'b1;
    bus.CRQ_n   = 1'b1;
    wait_idle("t3_c2_done");

    $display("[TB] test 4: memory beats I/O within CPU class");
    bus.CRQ_n  = 1'b0;
    bus.IORQ_n = 1'b0;
    expect_grant("t4_mem", G_C);
    bus.CRQ_n = 1'b1;
    wait_idle("t4_mem_done");
    expect_grant("t4_io", G_IO);
    bus.IORQ_n = 1'b1;
    wait_idle("t4_io_done");
    bus.IBDRY_n = 1'b1;

    $display("[TB] test 6a: CLEAR_n during APR");
    @(negedge sysclk);
    bus.IORQ_n = 1'b0;
    @(negedge sysclk);
    check_output("t6_grant", obs, vec(G_IO, 1'b1, 1'b1, 1'b0, 1'b1));
    bus.IORQ_n = 1'b1;
    @(negedge sysclk);
    check_output("t6_apr", obs, vec(G_IO, 1'b0, 1'b1, 1'b0, 1'b1));
    bus.CLEAR_n = 1'b0;
    #1 check_output("t6_clear_no_err", {7'h0, bus.BERROR_n}, 8'h01);
    @(negedge sysclk);
    check_output("t6_cleared", obs, IDLE_V);
    bus.CLEAR_n = 1'b1;

    $display("[TB] test 6b: parity error pulse");
    bus.CRQ_n    = 1'b0;
    bus.IBPERR_n = 1'b0;
    @(negedge sysclk);
    check_output("t6p_grant", obs, vec(G_C, 1'b1, 1'b1, 1'b0, 1'b1));
    bus.CRQ_n = 1'b1;
    repeat (3) @(negedge sysclk);
    check_output("t6p_wait_no_dry", obs, vec(G_C, 1'b1, 1'b1, 1'b0, 1'b1));
    bus.IBDRY_n = 1'b0;
    #1 check_output("t6p_pulse", obs, vec(G_C, 1'b1, 1'b1, 1'b0, 1'b0));
    @(negedge sysclk);
    check_output("t6p_done", obs, vec(G_NO, 1'b1, 1'b1, 1'b0, 1'b1));
    bus.IBDRY_n  = 1'b1;
    bus.IBPERR_n = 1'b1;
    @(negedge sysclk);
    check_output("t6p_idle", obs, IDLE_V);

    $display("[TB] test 5: slave never answers");
    bus.CRQ_n = 1'b0;
    @(negedge sysclk);
    bus.CRQ_n = 1'b1;
    repeat (3) @(negedge sysclk);
    for (int c = 1; c <= 3; c++) begin
      check_output($sformatf("t5_wait_c%0d", c), obs, vec(G_C, 1'b1, 1'b1, 1'b0, 1'b1));
      @(negedge sysclk);
    end
`ifdef BIF_ARB_TIMEOUT_EN
    check_output("t5_tout_pulse", obs, vec(G_C, 1'b1, 1'b1, 1'b1, 1'b0));
    @(negedge sysclk);
    check_output("t5_released", obs, vec(G_NO, 1'b1, 1'b1, 1'b0, 1'b1));
    @(negedge sysclk);
    check_output("t5_idle", obs, IDLE_V);
`else
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      if (obs !== vec(G_C, 1'b1, 1'b1, 1'b0, 1'b1)) bad++;
      @(negedge sysclk);
    end
    check_output("t5_held_bad_cycles", 8'(bad), 8'd0);
    bus.CLEAR_n = 1'b0;
    @(negedge sysclk);
    check_output("t5_clear_idle", obs, IDLE_V);
    bus.CLEAR_n = 1'b1;
`endif

    $display("[TB] async reset mid-transfer");
    @(negedge sysclk);
    bus.CRQ_n = 1'b0;
    @(negedge sysclk);
    bus.CRQ_n = 1'b1;
    @(negedge sysclk);
    check_output("rst_pre_apr", obs, vec(G_C, 1'b0, 1'b1, 1'b0, 1'b1));
    sys_rst = 1'b1;
    #1 check_output("rst_async_release", obs, IDLE_V);
    @(negedge sysclk);
    sys_rst = 1'b0;
    @(negedge sysclk);
    check_output("rst_after", obs, IDLE_V);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
